// File: rtl/sm4_axis_s.sv
// AXI4-Stream slave front end for the SM4 core: gathers a 9-beat frame
// (header, 128-bit key, 128-bit data) and flags frame start and completion.
module sm4_axis_s (
  input  logic         S_AXIS_ACLK,
  input  logic         S_AXIS_ARESETN,
  output logic         S_AXIS_TREADY,
  input  logic [31:0]  S_AXIS_TDATA,
  input  logic [3:0]   S_AXIS_TSTRB,
  input  logic         S_AXIS_TLAST,
  input  logic         S_AXIS_TVALID,
  output logic         isdec,
  output logic         start_input,
  output logic         end_input,
  output logic [127:0] datain,
  output logic [127:0] mkin
);

  // state   | meaning
  // ST_HDR  | waiting for the header beat (beat 0)
  // ST_KEY  | collecting master key words (beats 1..4)
  // ST_DATA | collecting data words (beats 5..8)
  typedef enum logic [1:0] {ST_HDR, ST_KEY, ST_DATA} state_t;

  state_t       state, state_next;
  logic [3:0]   beat_cnt, beat_cnt_next;
  logic [127:0] key_sh, data_sh;
  logic         isdec_next;
  logic         accept, abort;
  logic         start_d, end_d, key_shift, data_shift;

  // Strobes carry no information for this block.
  logic unused_tstrb;
  assign unused_tstrb = ^S_AXIS_TSTRB;

  assign S_AXIS_TREADY = ~S_AXIS_ARESETN;
  assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;
  assign abort         = accept & S_AXIS_TLAST & (beat_cnt != 4'd8);

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESETN) begin
    if (S_AXIS_ARESETN) begin
      state    <= ST_HDR;
      beat_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    if (abort) begin
      state_next    = ST_HDR;
      beat_cnt_next = 4'd0;
    end else if (accept) begin
      beat_cnt_next = (beat_cnt == 4'd8) ? 4'd0 : beat_cnt + 4'd1;
      case (state)
        ST_HDR:  state_next = ST_KEY;
        ST_KEY:  if (beat_cnt == 4'd4) state_next = ST_DATA;
        ST_DATA: if (beat_cnt == 4'd8) state_next = ST_HDR;
        default: state_next = ST_HDR;
      endcase
    end
  end

  always_comb begin
    start_d    = 1'b0;
    end_d      = 1'b0;
    key_shift  = 1'b0;
    data_shift = 1'b0;
    if (accept && !abort) begin
      case (state)
        ST_HDR:  start_d = 1'b1;
        ST_KEY:  key_shift = 1'b1;
        ST_DATA: begin
          data_shift = 1'b1;
          end_d      = (beat_cnt == 4'd8);
        end
        default: ;
      endcase
    end
  end

  // The last data word goes straight to datain alongside the shadow copy.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESETN) begin
    if (S_AXIS_ARESETN) begin
      key_sh      <= '0;
      data_sh     <= '0;
      isdec_next  <= 1'b0;
      isdec       <= 1'b0;
      mkin        <= '0;
      datain      <= '0;
      start_input <= 1'b0;
      end_input   <= 1'b0;
    end else begin
      start_input <= start_d;
      end_input   <= end_d;
      if (start_d)    isdec_next <= S_AXIS_TDATA[0];
      if (key_shift)  key_sh     <= {key_sh[95:0], S_AXIS_TDATA};
      if (data_shift) data_sh    <= {data_sh[95:0], S_AXIS_TDATA};
      if (end_d) begin
        mkin   <= key_sh;
        datain <= {data_sh[95:0], S_AXIS_TDATA};
        isdec  <= isdec_next;
      end
    end
  end

endmodule

// File: tb/tb_sm4_axis_s.sv
// Scoreboard bench for sm4_axis_s: frame tasks queue expected pulses/values,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_sm4_axis_s;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tready;
  logic [31:0]  tdata = '0;
  logic [3:0]   tstrb = 4'hF;
  logic         tlast = 1'b0;
  logic         tvalid = 1'b0;
  logic         isdec, start_input, end_input;
  logic [127:0] datain, mkin;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int           cyc;
    logic         isdec;
    logic [127:0] mkin;
    logic [127:0] datain;
  } exp_end_t;

  int       start_q[$];
  exp_end_t end_q[$];

  localparam logic [127:0] ENC_BLK = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] DEC_BLK = 128'h681EDF34D206965E86B3E94F536E4246;
  localparam logic [127:0] REP_BLK = 128'h12344321123443211234432112344321;
  localparam logic [127:0] KEY_C   = 128'hA5A5A5A55A5A5A5A0F0F0F0FF0F0F0F0;
  localparam logic [127:0] DAT_C   = 128'hDEADBEEFCAFEF00D0011223344556677;

  sm4_axis_s dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst),
    .S_AXIS_TREADY  (tready),
    .S_AXIS_TDATA   (tdata),
    .S_AXIS_TSTRB   (tstrb),
    .S_AXIS_TLAST   (tlast),
    .S_AXIS_TVALID  (tvalid),
    .isdec          (isdec),
    .start_input    (start_input),
    .end_input      (end_input),
    .datain         (datain),
    .mkin           (mkin)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (start_input) begin
        if (start_q.size() == 0) chk("start_unexpected", 1, 0);
        else chk("start_cycle", 128'(cyc), 128'(start_q.pop_front()));
      end
      if (end_input) begin
        if (end_q.size() == 0) chk("end_unexpected", 1, 0);
        else begin
          exp_end_t e;
          e = end_q.pop_front();
          chk("end_cycle", 128'(cyc), 128'(e.cyc));
          chk("end_isdec", 128'(isdec), 128'(e.isdec));
          chk("end_mkin", mkin, e.mkin);
          chk("end_datain", datain, e.datain);
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // abort_at: beat carrying an early TLAST; stop_after: stop sending after
  // that beat (no completion); gap_after: idle cycles inserted after that beat.
  task automatic send_frame(input logic [31:0] hdr, input logic [127:0] key,
                            input logic [127:0] dat, input int gap_after,
                            input int gaps, input int abort_at, input int stop_after,
                            input logic [127:0] exp_key, input logic [127:0] exp_dat,
                            input logic exp_isdec);
    logic [31:0] w [9];
    exp_end_t e;
    w[0] = hdr;
    for (int i = 0; i < 4; i++) begin
      w[1+i] = key[127-32*i -: 32];
      w[5+i] = dat[127-32*i -: 32];
    end
    for (int i = 0; i < 9; i++) begin
      send_beat(w[i], (i == abort_at) || (i == 8));
      if (i == abort_at) break;
      if (i == 0) start_q.push_back(cyc);
      if (i == 8) begin
        e.cyc = cyc; e.isdec = exp_isdec; e.mkin = exp_key; e.datain = exp_dat;
        end_q.push_back(e);
      end
      if (i == stop_after) break;
      if (i == gap_after) idle(gaps);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic exp_isdec,
                             input logic [127:0] exp_key, input logic [127:0] exp_dat);
    chk({tag, "_isdec"}, 128'(isdec), 128'(exp_isdec));
    chk({tag, "_mkin"}, mkin, exp_key);
    chk({tag, "_datain"}, datain, exp_dat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for 5 cycles.
    repeat (5) @(posedge clk);
    #1;
    chk("rst_tready", 128'(tready), 0);
    chk("rst_start", 128'(start_input), 0);
    chk("rst_end", 128'(end_input), 0);
    chk_outputs("rst", 1'b0, '0, '0);
    rst = 1'b0;
    #1;
    chk("tready_after_rst", 128'(tready), 1);
    idle(2);

    // Encrypt frame, back-to-back.
    send_frame(32'h10101010, ENC_BLK, ENC_BLK, -1, 0, -1, -1, ENC_BLK, ENC_BLK, 1'b0);
    idle(3);
    chk_outputs("enc", 1'b0, ENC_BLK, ENC_BLK);

    // Decrypt frame followed immediately by a constant-word frame.
    send_frame(32'h00000001, DEC_BLK, DEC_BLK, -1, 0, -1, -1, DEC_BLK, DEC_BLK, 1'b1);
    send_frame(32'h12344321, REP_BLK, REP_BLK, -1, 0, -1, -1, REP_BLK, REP_BLK, 1'b1);
    idle(3);
    chk_outputs("rep", 1'b1, REP_BLK, REP_BLK);

    // Gaps between beats 3 and 4.
    send_frame(32'h10101010, ENC_BLK, ENC_BLK, 3, 4, -1, -1, ENC_BLK, ENC_BLK, 1'b0);
    idle(3);
    chk_outputs("gap", 1'b0, ENC_BLK, ENC_BLK);

    // Early TLAST on beat 5: outputs must hold, next beat is a header.
    send_frame(32'h00000001, KEY_C, DAT_C, -1, 0, 5, -1, '0, '0, 1'b0);
    idle(3);
    chk_outputs("abort", 1'b0, ENC_BLK, ENC_BLK);
    send_frame(32'h00000001, KEY_C, DAT_C, -1, 0, -1, -1, KEY_C, DAT_C, 1'b1);
    idle(3);
    chk_outputs("post_abort", 1'b1, KEY_C, DAT_C);

    // One-beat gap between two frames keeps pulses separate.
    send_frame(32'h00000000, DEC_BLK, ENC_BLK, -1, 0, -1, -1, DEC_BLK, ENC_BLK, 1'b0);
    idle(1);
    send_frame(32'h00000001, ENC_BLK, DEC_BLK, -1, 0, -1, -1, ENC_BLK, DEC_BLK, 1'b1);
    idle(3);

    // Reset after beat 6, asserted between clock edges.
    send_frame(32'h00000000, DAT_C, KEY_C, -1, 0, -1, 6, '0, '0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_tready", 128'(tready), 0);
    chk_outputs("midrst", 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_pulses", 128'({start_input, end_input}), 0);
    rst = 1'b0;
    idle(1);
    send_frame(32'h00000001, DAT_C, KEY_C, -1, 0, -1, -1, DAT_C, KEY_C, 1'b1);
    idle(3);
    chk_outputs("after_rst", 1'b1, DAT_C, KEY_C);

    chk("start_q_empty", 128'(start_q.size()), 0);
    chk("end_q_empty", 128'(end_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm4_axis_s.md
Name: sm4_axis_s

Overview:
AXI4-Stream slave front end for the SM4 block cipher core. It receives one 9-beat, 32-bit frame: a command header, a 128-bit master key and a 128-bit data block. It assembles the frame into 128-bit registers and signals the core when a frame has started and when it is complete. It sits between the DMA/stream source and the SM4 key-expansion and round logic.

Parameters:
None. Data width is fixed at 32 bits and the frame length at 9 beats.

Ports:
S_AXIS_ACLK  in  1  clock; all logic is rising-edge.
S_AXIS_ARESETN  in  1  asynchronous, active-high reset. The name is kept for interface compatibility; 1 = reset.
S_AXIS_TREADY  out  1  slave ready.
S_AXIS_TDATA  in  32  stream data.
S_AXIS_TSTRB  in  4  byte strobes; ignored, all bytes are treated as valid.
S_AXIS_TLAST  in  1  end-of-packet marker.
S_AXIS_TVALID  in  1  master valid.
isdec  out  1  operation mode from the header: 1 = decrypt, 0 = encrypt.
start_input  out  1  one-cycle pulse when a header beat is accepted.
end_input  out  1  one-cycle pulse when a complete frame has been captured.
datain  out  128  assembled data block.
mkin  out  128  assembled master key.

Behaviour:
- Beat acceptance: a beat is accepted on a rising edge where TVALID=1 and TREADY=1.
- TREADY: 0 while reset is asserted; 1 at all other times. The block never back-pressures.
- Beat counter: a 4-bit counter, 0..8, counts accepted beats in the current frame.
- Beat 0 (header):
  - Capture isdec_next = TDATA[0].
  - start_input = 1 in the following cycle.
- Beats 1..4: master key, most-significant word first.
  - Beat 1 maps to key[127:96], beat 4 maps to key[31:0].
  - Words are shifted into an internal key shadow register.
- Beats 5..8: data block, most-significant word first.
  - Beat 5 maps to data[127:96], beat 8 maps to data[31:0].
  - Words are shifted into an internal data shadow register.
- Frame completion, on acceptance of beat 8:
  - Copy the shadow registers to mkin and datain, and update isdec, all in the same edge.
  - end_input = 1 for exactly the next cycle.
  - The counter returns to 0; the next accepted beat is a new header.
- Output stability: mkin, datain and isdec change only at frame completion and hold their value between completions.
- TLAST on beats 0..7: abort the frame.
  - The counter returns to 0.
  - No end_input pulse; mkin, datain and isdec are unchanged.
  - The aborting beat's data is discarded.
- TLAST on beat 8: normal completion.
- Pulse rules:
  - start_input and end_input are registered single-cycle pulses and are 0 in every other cycle.
  - A one-beat gap between frames does not merge pulses.
- TVALID=0 cycles: no state change; the counter holds. Gaps inside a frame are allowed.
- Reset (asynchronous, any time, including mid-frame):
  - Counter = 0.
  - start_input = 0, end_input = 0, isdec = 0.
  - datain = 128'h0, mkin = 128'h0; shadow registers cleared.
  - After release, the first accepted beat is treated as a header.

Test Plan:
- Reset: hold reset 5 cycles -> TREADY=0, start_input=0, end_input=0, isdec=0, datain=0, mkin=0. After release -> TREADY=1.
- Encrypt frame, back-to-back beats:
  - Stimulus: 10101010, 01234567, 89ABCDEF, FEDCBA98, 76543210, 01234567, 89ABCDEF, FEDCBA98, 76543210.
  - Response: start_input pulses 1 cycle after beat 0; end_input pulses 1 cycle after beat 8.
  - Values: mkin = datain = 0123456789ABCDEFFEDCBA9876543210; isdec=0.
- Decrypt and continuous valid:
  - Send header 00000001 plus key/data 68 1E DF 34 D2 06 96 5E 86 B3 E9 4F 53 6E 42 46 -> isdec=1, datain=681EDF34D206965E86B3E94F536E4246.
  - Then hold TVALID=1 with TDATA=12344321 for 9 more beats -> a second start_input/end_input pair; mkin = datain = 12344321 repeated four times; isdec=1 (bit 0 of header 12344321).
- Gaps: insert TVALID=0 cycles between beats 3 and 4 -> same result as the unbroken frame; end_input asserted once.
- Early TLAST on beat 5 -> no end_input; previous mkin/datain/isdec retained; the next beat starts a new header with a start_input pulse.
- Mid-frame reset after beat 6 -> all outputs cleared; a full following frame completes correctly.
